// File: rtl/wb_shared_arbiter.sv
// wb_shared_arbiter: round-robin share of one Wishbone master port between iBus and dBus, with a strobe timeout.
module wb_shared_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] iBusWishbone_ADR,
  input  logic [3:0]  iBusWishbone_SEL,
  input  logic        iBusWishbone_CYC,
  input  logic        iBusWishbone_STB,
  output logic [31:0] iBusWishbone_DAT_MISO,
  output logic        iBusWishbone_ACK,
  output logic        iBusWishbone_ERR,
  input  logic [29:0] dBusWishbone_ADR,
  input  logic [31:0] dBusWishbone_DAT_MOSI,
  input  logic [3:0]  dBusWishbone_SEL,
  input  logic        dBusWishbone_CYC,
  input  logic        dBusWishbone_STB,
  input  logic        dBusWishbone_WE,
  output logic [31:0] dBusWishbone_DAT_MISO,
  output logic        dBusWishbone_ACK,
  output logic        dBusWishbone_ERR,
  output logic [29:0] busWishbone_ADR,
  output logic [31:0] busWishbone_DAT_MOSI,
  output logic [3:0]  busWishbone_SEL,
  output logic        busWishbone_CYC,
  output logic        busWishbone_STB,
  output logic        busWishbone_WE,
  input  logic [31:0] busWishbone_DAT_MISO,
  input  logic        busWishbone_ACK,
  input  logic        busWishbone_ERR
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state;
  logic last_d;
  logic [15:0] cnt;
  logic gi, gd, own_cyc, own_stb, own_req, rsp_ack, rsp_err, to, i_req, d_req;
  assign gi = state == GRANT_I;
  assign gd = state == GRANT_D;
  assign i_req = iBusWishbone_CYC & iBusWishbone_STB;
  assign d_req = dBusWishbone_CYC & dBusWishbone_STB;
  assign own_cyc = gi ? iBusWishbone_CYC : gd ? dBusWishbone_CYC : 1'b0;
  assign own_stb = gi ? iBusWishbone_STB : gd ? dBusWishbone_STB : 1'b0;
  assign own_req = own_cyc & own_stb;
  assign rsp_ack = own_req & busWishbone_ACK;
  assign rsp_err = own_req & busWishbone_ERR;
  // A slave response in the final cycle beats the timeout.
  assign to = own_req & ~busWishbone_ACK & ~busWishbone_ERR & (cnt == 16'(TIMEOUT - 1));
  assign busWishbone_ADR = gi ? iBusWishbone_ADR : gd ? dBusWishbone_ADR : '0;
  assign busWishbone_SEL = gi ? iBusWishbone_SEL : gd ? dBusWishbone_SEL : '0;
  assign busWishbone_DAT_MOSI = gd ? dBusWishbone_DAT_MOSI : '0;
  assign busWishbone_WE = gd & dBusWishbone_WE;
  assign busWishbone_CYC = own_cyc & ~to;
  assign busWishbone_STB = own_stb & ~to;
  assign iBusWishbone_ACK = gi & rsp_ack;
  assign iBusWishbone_ERR = gi & (rsp_err | to);
  assign dBusWishbone_ACK = gd & rsp_ack;
  assign dBusWishbone_ERR = gd & (rsp_err | to);
  assign iBusWishbone_DAT_MISO = busWishbone_DAT_MISO;
  assign dBusWishbone_DAT_MISO = busWishbone_DAT_MISO;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b1;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (i_req && (!d_req || last_d)) begin
        state <= GRANT_I;
        last_d <= 1'b0;
        cnt <= '0;
      end else if (d_req) begin
        state <= GRANT_D;
        last_d <= 1'b1;
        cnt <= '0;
      end
    end else if (rsp_ack || rsp_err || to || !own_cyc) begin
      state <= IDLE;
    end else if (own_stb) begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_wb_shared_arbiter.sv
// tb_wb_shared_arbiter: directed stimulus with a response scoreboard for wb_shared_arbiter.
module tb_wb_shared_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [29:0] iBusWishbone_ADR, dBusWishbone_ADR, busWishbone_ADR;
  logic [3:0]  iBusWishbone_SEL, dBusWishbone_SEL, busWishbone_SEL;
  logic        iBusWishbone_CYC, iBusWishbone_STB, iBusWishbone_ACK, iBusWishbone_ERR;
  logic        dBusWishbone_CYC, dBusWishbone_STB, dBusWishbone_WE, dBusWishbone_ACK, dBusWishbone_ERR;
  logic [31:0] iBusWishbone_DAT_MISO, dBusWishbone_DAT_MISO, dBusWishbone_DAT_MOSI;
  logic [31:0] busWishbone_DAT_MOSI, busWishbone_DAT_MISO;
  logic        busWishbone_CYC, busWishbone_STB, busWishbone_WE, busWishbone_ACK, busWishbone_ERR;
  wb_shared_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .iBusWishbone_ADR(iBusWishbone_ADR), .iBusWishbone_SEL(iBusWishbone_SEL),
    .iBusWishbone_CYC(iBusWishbone_CYC), .iBusWishbone_STB(iBusWishbone_STB),
    .iBusWishbone_DAT_MISO(iBusWishbone_DAT_MISO), .iBusWishbone_ACK(iBusWishbone_ACK),
    .iBusWishbone_ERR(iBusWishbone_ERR),
    .dBusWishbone_ADR(dBusWishbone_ADR), .dBusWishbone_DAT_MOSI(dBusWishbone_DAT_MOSI),
    .dBusWishbone_SEL(dBusWishbone_SEL), .dBusWishbone_CYC(dBusWishbone_CYC),
    .dBusWishbone_STB(dBusWishbone_STB), .dBusWishbone_WE(dBusWishbone_WE),
    .dBusWishbone_DAT_MISO(dBusWishbone_DAT_MISO), .dBusWishbone_ACK(dBusWishbone_ACK),
    .dBusWishbone_ERR(dBusWishbone_ERR),
    .busWishbone_ADR(busWishbone_ADR), .busWishbone_DAT_MOSI(busWishbone_DAT_MOSI),
    .busWishbone_SEL(busWishbone_SEL), .busWishbone_CYC(busWishbone_CYC),
    .busWishbone_STB(busWishbone_STB), .busWishbone_WE(busWishbone_WE),
    .busWishbone_DAT_MISO(busWishbone_DAT_MISO), .busWishbone_ACK(busWishbone_ACK),
    .busWishbone_ERR(busWishbone_ERR)
  );
  typedef struct packed {
    logic [3:0]  rsp;
    logic [31:0] miso;
    logic [29:0] adr;
    logic [31:0] mosi;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } exp_t;
  exp_t q[$];
  string nq[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_rsp(input string nm, input logic [3:0] rsp, input logic [31:0] miso,
                            input logic [29:0] adr, input logic [31:0] mosi, input logic [3:0] sel,
                            input logic we, input logic cyc);
    q.push_back({rsp, miso, adr, mosi, sel, we, cyc});
    nq.push_back(nm);
  endtask
  task automatic idle_all;
    iBusWishbone_ADR = '0; iBusWishbone_SEL = '0; iBusWishbone_CYC = 0; iBusWishbone_STB = 0;
    dBusWishbone_ADR = '0; dBusWishbone_DAT_MOSI = '0; dBusWishbone_SEL = '0;
    dBusWishbone_CYC = 0; dBusWishbone_STB = 0; dBusWishbone_WE = 0;
    busWishbone_DAT_MISO = '0; busWishbone_ACK = 0; busWishbone_ERR = 0;
  endtask
  task automatic set_i(input logic [29:0] adr, input logic req);
    iBusWishbone_ADR = adr; iBusWishbone_SEL = 4'hF; iBusWishbone_CYC = req; iBusWishbone_STB = req;
  endtask
  task automatic set_d(input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input logic req);
    dBusWishbone_ADR = adr; dBusWishbone_DAT_MOSI = dat; dBusWishbone_SEL = sel;
    dBusWishbone_WE = we; dBusWishbone_CYC = req; dBusWishbone_STB = req;
  endtask
  always @(negedge clk) begin
    if (iBusWishbone_ACK | iBusWishbone_ERR | dBusWishbone_ACK | dBusWishbone_ERR) begin
      exp_t g, e;
      string nm;
      g = {iBusWishbone_ACK, iBusWishbone_ERR, dBusWishbone_ACK, dBusWishbone_ERR,
           (iBusWishbone_ACK | iBusWishbone_ERR) ? iBusWishbone_DAT_MISO : dBusWishbone_DAT_MISO,
           busWishbone_ADR, busWishbone_DAT_MOSI, busWishbone_SEL, busWishbone_WE, busWishbone_CYC};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got %h expected no response", g);
      end else begin
        e = q.pop_front();
        nm = nq.pop_front();
        if (g !== e) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", nm, g, e);
        end
      end
    end
  end
  initial begin
    idle_all();
    reset = 1;
    tick(); tick();
    chk("reset_shared", {busWishbone_CYC, busWishbone_STB, busWishbone_WE, busWishbone_ADR}, 0);
    chk("reset_rsp", {iBusWishbone_ACK, iBusWishbone_ERR, dBusWishbone_ACK, dBusWishbone_ERR}, 0);
    reset = 0;
    // single iBus fetch
    set_i(30'h0000100, 1);
    chk("i_latency", busWishbone_CYC, 0);
    tick();
    chk("i_grant", {busWishbone_CYC, busWishbone_STB, busWishbone_WE, busWishbone_ADR}, {3'b110, 30'h0000100});
    expect_rsp("i_ack", 4'b1000, 32'hCAFE, 30'h0000100, 0, 4'hF, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'hCAFE;
    tick();
    idle_all();
    chk("i_release", busWishbone_CYC, 0);
    // slave response while idle is dropped
    busWishbone_ACK = 1; busWishbone_ERR = 1;
    #1;
    chk("idle_rsp", {iBusWishbone_ACK, iBusWishbone_ERR, dBusWishbone_ACK, dBusWishbone_ERR}, 0);
    tick();
    idle_all();
    // ties alternate starting from iBus after reset
    reset = 1; tick(); reset = 0;
    set_i(30'h11, 1); set_d(30'h22, 0, 4'h3, 0, 1);
    tick();
    chk("tie1_i", busWishbone_ADR, 30'h11);
    expect_rsp("tie1_ack", 4'b1000, 32'h1, 30'h11, 0, 4'hF, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'h1;
    tick();
    busWishbone_ACK = 0;
    tick();
    chk("tie2_d", busWishbone_ADR, 30'h22);
    expect_rsp("tie2_ack", 4'b0010, 32'h2, 30'h22, 0, 4'h3, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'h2;
    tick();
    busWishbone_ACK = 0;
    tick();
    chk("tie3_i", busWishbone_ADR, 30'h11);
    expect_rsp("tie3_ack", 4'b1000, 32'h3, 30'h11, 0, 4'hF, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'h3;
    tick();
    idle_all();
    // dBus store with slave error while iBus waits
    set_i(30'h33, 1); set_d(30'h20800C00, 32'h41, 4'b0001, 1, 1);
    tick();
    chk("d_store", {busWishbone_WE, busWishbone_ADR, busWishbone_DAT_MOSI, busWishbone_SEL},
        {1'b1, 30'h20800C00, 32'h41, 4'b0001});
    expect_rsp("d_err", 4'b0001, 32'h0, 30'h20800C00, 32'h41, 4'b0001, 1, 1);
    busWishbone_ERR = 1;
    tick();
    busWishbone_ERR = 0; set_d(0, 0, 0, 0, 0);
    chk("i_held", {iBusWishbone_ACK, iBusWishbone_ERR}, 0);
    tick();
    chk("i_after_d", busWishbone_ADR, 30'h33);
    expect_rsp("i_after_d_ack", 4'b1000, 32'h5, 30'h33, 0, 4'hF, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'h5;
    tick();
    idle_all();
    // timeout: error three cycles after grant
    set_i(30'h44, 1);
    tick();
    expect_rsp("timeout", 4'b0100, 32'h0, 30'h44, 0, 4'hF, 0, 0);
    chk("to_c0", iBusWishbone_ERR, 0);
    tick();
    chk("to_c1", iBusWishbone_ERR, 0);
    tick();
    chk("to_c2", iBusWishbone_ERR, 0);
    tick();
    tick();
    idle_all();
    chk("to_idle", busWishbone_CYC, 0);
    // ACK on the timeout cycle wins
    set_i(30'h45, 1);
    tick(); tick(); tick(); tick();
    expect_rsp("ack_wins", 4'b1000, 32'h77, 30'h45, 0, 4'hF, 0, 1);
    busWishbone_ACK = 1; busWishbone_DAT_MISO = 32'h77;
    tick();
    idle_all();
    // reset in GRANT_D aborts pending ack
    set_d(30'h55, 0, 4'hF, 0, 1);
    tick();
    chk("d_grant", {busWishbone_CYC, busWishbone_ADR}, {1'b1, 30'h55});
    reset = 1;
    tick();
    busWishbone_ACK = 1;
    #1;
    chk("rst_abort_rsp", {dBusWishbone_ACK, dBusWishbone_ERR, iBusWishbone_ACK, iBusWishbone_ERR}, 0);
    chk("rst_abort_bus", {busWishbone_CYC, busWishbone_STB, busWishbone_WE, busWishbone_ADR}, 0);
    idle_all();
    tick();
    reset = 0;
    tick();
    chk("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_shared_arbiter.md
WB_SHARED_ARBITER -- requirements
Module: wb_shared_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles a granted strobe may wait for ACK/ERR before a forced error; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port iBusWishbone_ADR  in  30  instruction-fetch word address.
REQ-005 SHALL have port iBusWishbone_SEL  in  4  instruction-fetch byte select.
REQ-006 SHALL have port iBusWishbone_CYC  in  1  instruction-fetch cycle request.
REQ-007 SHALL have port iBusWishbone_STB  in  1  instruction-fetch strobe.
REQ-008 SHALL have port iBusWishbone_DAT_MISO  out  32  read data to fetch master.
REQ-009 SHALL have port iBusWishbone_ACK  out  1  fetch termination, success.
REQ-010 SHALL have port iBusWishbone_ERR  out  1  fetch termination, error.
REQ-011 SHALL have port dBusWishbone_ADR  in  30  load/store word address.
REQ-012 SHALL have port dBusWishbone_DAT_MOSI  in  32  store data.
REQ-013 SHALL have port dBusWishbone_SEL  in  4  load/store byte select.
REQ-014 SHALL have port dBusWishbone_CYC  in  1  load/store cycle request.
REQ-015 SHALL have port dBusWishbone_STB  in  1  load/store strobe.
REQ-016 SHALL have port dBusWishbone_WE  in  1  store when 1.
REQ-017 SHALL have port dBusWishbone_DAT_MISO  out  32  load data to data master.
REQ-018 SHALL have port dBusWishbone_ACK  out  1  load/store termination, success.
REQ-019 SHALL have port dBusWishbone_ERR  out  1  load/store termination, error.
REQ-020 SHALL have ports busWishbone_ADR out 30, _DAT_MOSI out 32, _SEL out 4, _CYC out 1, _STB out 1, _WE out 1: shared master toward interconnect.
REQ-021 SHALL have ports busWishbone_DAT_MISO in 32, _ACK in 1, _ERR in 1: shared slave response.

Function
REQ-022 SHALL implement states IDLE, GRANT_I, GRANT_D plus a 1-bit last_grant register (I/D) and a 16-bit wait counter.
REQ-023 IDLE: all shared outputs 0; iBus/dBus ACK and ERR 0.
REQ-024 IDLE transition: only iBus CYC&STB -> GRANT_I; only dBus CYC&STB -> GRANT_D; both -> grant the side not equal to last_grant; grant latency exactly 1 cycle.
REQ-025 On entering GRANT_x, last_grant SHALL be set to x and wait counter cleared to 0.
REQ-026 GRANT_I: shared ADR/SEL/CYC/STB from iBus, WE=0, DAT_MOSI=0; GRANT_D: all shared outputs from dBus, combinationally same cycle.
REQ-027 Owner ACK/ERR SHALL equal shared ACK/ERR gated by owner CYC&STB; non-owner ACK/ERR SHALL be 0.
REQ-028 Both DAT_MISO outputs SHALL carry busWishbone_DAT_MISO unconditionally.
REQ-029 Granted state SHALL return to IDLE the cycle after owner ACK or ERR is asserted, or after owner CYC is sampled low.
REQ-030 Wait counter SHALL increment each granted cycle with owner STB high and no ACK/ERR; saturation never reached.
REQ-031 When counter equals TIMEOUT-1 with no ACK/ERR: owner ERR=1 for that one cycle, shared CYC/STB forced 0 that cycle, next state IDLE.
REQ-032 Shared ACK or ERR arriving in IDLE SHALL be ignored and not forwarded.
REQ-033 Simultaneous slave ACK and timeout in same cycle: ACK wins, ERR not asserted.
REQ-034 Non-owner requests SHALL be held off (no ACK/ERR) until owner releases; round-robin guarantees service within one transaction.

Reset
REQ-035 With reset high at a clock edge: state IDLE, last_grant=D (iBus wins first tie), counter 0; every output 0 from the following cycle.
REQ-036 Reset mid-transaction SHALL abort it with no ACK/ERR forwarded after the reset edge.

Verification
REQ-037 iBus alone requests ADR=0x0000100 -> busWishbone_CYC=1 one cycle later with ADR=0x0000100, WE=0; slave ACK -> iBusWishbone_ACK=1 same cycle, IDLE next.
REQ-038 Both request at once after reset -> iBus granted first; next tie -> dBus granted; third tie -> iBus.
REQ-039 dBus store ADR=0x20800C00 (word), DAT_MOSI=0x41, SEL=0001 -> shared WE=1 with same values; ERR from slave -> dBusWishbone_ERR=1, iBus ACK/ERR stay 0.
REQ-040 TIMEOUT=4, slave never responds -> owner ERR=1 exactly 3 cycles after grant (counter 0..3), shared CYC=0 that cycle.
REQ-041 Reset asserted during GRANT_D with pending slave ACK -> no dBus ACK after edge; all outputs 0, state IDLE.
